// File: rtl/region_mmu_pkg.sv
// region_mmu_pkg: shared FSM/fault types, funct3 size codes and the default region map.
package region_mmu_pkg;
  typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE, S_FAULT} state_e;
  typedef enum logic [2:0] {
    C_NONE     = 3'd0,
    C_BADMODE  = 3'd1,
    C_MISALIGN = 3'd2,
    C_UNMAPPED = 3'd3,
    C_WPROT    = 3'd4,
    C_TIMEOUT  = 3'd5
  } cause_e;
  localparam logic [2:0] MODE_B  = 3'b000;
  localparam logic [2:0] MODE_H  = 3'b001;
  localparam logic [2:0] MODE_W  = 3'b010;
  localparam logic [2:0] MODE_BU = 3'b100;
  localparam logic [2:0] MODE_HU = 3'b101;
  // Entry 0 is the leftmost mark: IMEM, DMEM, FB, DEVICE
  localparam logic [15:0] DEF_MARKS = {4'h0, 4'h8, 4'hc, 4'ha};
  localparam logic [3:0]  DEF_WMASK = 4'b1110;
  function automatic logic bad_mode(input logic [2:0] m);
    return !(m inside {MODE_B, MODE_H, MODE_W, MODE_BU, MODE_HU});
  endfunction
  function automatic logic misaligned(input logic [2:0] m, input logic [1:0] a);
    return (m[1:0] == MODE_H[1:0] && a[0]) || (m[1:0] == MODE_W[1:0] && a != 2'b00);
  endfunction
endpackage

// File: rtl/region_mmu_decode.sv
// region_mmu_decode: combinational legality check of one access against the region table.
module region_mmu_decode
  import region_mmu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SLAVE_WIDTH = 4,
  parameter int NREGION = 4,
  parameter logic [NREGION*SLAVE_WIDTH-1:0] REGION_MARKS = DEF_MARKS,
  parameter logic [NREGION-1:0] REGION_WMASK = DEF_WMASK,
  localparam int IW = NREGION > 1 ? $clog2(NREGION) : 1
) (
  input  logic [XLEN-1:0] addr,
  input  logic [2:0]      mode,
  input  logic            wen,
  output logic            hit,
  output logic [IW-1:0]   idx,
  output cause_e          cause
);
  logic addr_unused;
  assign addr_unused = ^addr[XLEN-SLAVE_WIDTH-1:2];
  // Scan from the top so the lowest matching index is the one left standing
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NREGION-1; i >= 0; i--)
      if (addr[XLEN-1 -: SLAVE_WIDTH] == REGION_MARKS[(NREGION-1-i)*SLAVE_WIDTH +: SLAVE_WIDTH]) begin
        hit = 1'b1;
        idx = IW'(i);
      end
    cause = bad_mode(mode)              ? C_BADMODE  :
            misaligned(mode, addr[1:0]) ? C_MISALIGN :
            !hit                        ? C_UNMAPPED :
            (wen && !REGION_WMASK[idx]) ? C_WPROT    : C_NONE;
  end
endmodule

// File: rtl/region_mmu.sv
// region_mmu: decodes CPU MMIO accesses against a region table and runs legal ones
// as a single registered UIBI transaction with a bounded wait for bus_ready.
module region_mmu
  import region_mmu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SLAVE_WIDTH = 4,
  parameter int NREGION = 4,
  parameter logic [NREGION*SLAVE_WIDTH-1:0] REGION_MARKS = DEF_MARKS,
  parameter logic [NREGION-1:0] REGION_WMASK = DEF_WMASK,
  parameter int TIMEOUT = 255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        mem_req,
  input  logic                        mem_wen,
  input  logic [2:0]                  mem_mode,
  input  logic [XLEN-1:0]             mem_addr,
  input  logic [XLEN-1:0]             mem_dat_i,
  output logic [XLEN-1:0]             mem_dat_o,
  output logic                        mem_ready_o,
  output logic                        mem_fault_o,
  output logic [2:0]                  fault_cause_o,
  output logic                        bus_req,
  output logic                        bus_wen,
  output logic [2:0]                  bus_mode,
  output logic [SLAVE_WIDTH-1:0]      bus_num,
  output logic [XLEN-SLAVE_WIDTH-1:0] bus_addr,
  output logic [XLEN-1:0]             bus_dat_o,
  input  logic [XLEN-1:0]             bus_dat_i,
  input  logic                        bus_ready
);
  localparam int IW = NREGION > 1 ? $clog2(NREGION) : 1;
  localparam logic [7:0] TMO = 8'(TIMEOUT);
  state_e state_q, state_d;
  cause_e cause_q, cause_d, dec_cause;
  logic [7:0] cnt_q, cnt_d;
  logic wen_q, wen_d, req_q, req_d, ready_q, ready_d, fault_q, fault_d, hit;
  logic [2:0] mode_q, mode_d;
  logic [XLEN-1:0] addr_q, addr_d, wdat_q, wdat_d, rdat_q, rdat_d;
  logic [IW-1:0] idx_unused;
  region_mmu_decode #(
    .XLEN(XLEN), .SLAVE_WIDTH(SLAVE_WIDTH), .NREGION(NREGION),
    .REGION_MARKS(REGION_MARKS), .REGION_WMASK(REGION_WMASK)
  ) u_decode (
    .addr(mem_addr), .mode(mem_mode), .wen(mem_wen),
    .hit(hit), .idx(idx_unused), .cause(dec_cause)
  );
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    cnt_d   = cnt_q;
    wen_d   = wen_q;
    mode_d  = mode_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    req_d   = req_q;
    ready_d = 1'b0;
    fault_d = 1'b0;
    case (state_q)
      S_IDLE: if (mem_req) begin
        wen_d  = mem_wen;
        mode_d = mem_mode;
        addr_d = mem_addr;
        wdat_d = mem_dat_i;
        cnt_d  = '0;
        if (hit && dec_cause == C_NONE) begin
          state_d = S_BUS;
          req_d   = 1'b1;
          cause_d = C_NONE;
        end else begin
          state_d = S_FAULT;
          fault_d = 1'b1;
          cause_d = dec_cause;
        end
      end
      S_BUS: begin
        cnt_d = cnt_q + 8'd1;
        // A response arriving on the last allowed cycle still counts as success
        if (bus_ready) begin
          rdat_d  = bus_dat_i;
          req_d   = 1'b0;
          ready_d = 1'b1;
          state_d = S_DONE;
        end else if (cnt_d == TMO) begin
          req_d   = 1'b0;
          fault_d = 1'b1;
          cause_d = C_TIMEOUT;
          state_d = S_FAULT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      cause_q <= C_NONE;
      cnt_q   <= '0;
      wen_q   <= 1'b0;
      mode_q  <= '0;
      addr_q  <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      req_q   <= 1'b0;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      req_q   <= req_d;
      ready_q <= ready_d;
      fault_q <= fault_d;
    end
  assign mem_dat_o     = rdat_q;
  assign mem_ready_o   = ready_q;
  assign mem_fault_o   = fault_q;
  assign fault_cause_o = cause_q;
  assign bus_req       = req_q;
  assign bus_wen       = wen_q;
  assign bus_mode      = mode_q;
  assign bus_num       = addr_q[XLEN-1 -: SLAVE_WIDTH];
  assign bus_addr      = addr_q[XLEN-SLAVE_WIDTH-1:0];
  assign bus_dat_o     = wdat_q;
endmodule

// File: tb/tb_region_mmu.sv
// tb_region_mmu: randomized and directed checks of region_mmu against a rule-level access model.
module tb_region_mmu;
  logic clk = 1'b0, rst_n = 1'b0, mem_req = 1'b0, mem_wen = 1'b0, bus_ready = 1'b0;
  logic [2:0] mem_mode = '0;
  logic [31:0] mem_addr = '0, mem_dat_i = '0, bus_dat_i = '0;
  logic [31:0] mem_dat_o, bus_dat_o;
  logic mem_ready_o, mem_fault_o, bus_req, bus_wen;
  logic [2:0] fault_cause_o, bus_mode;
  logic [3:0] bus_num;
  logic [27:0] bus_addr;
  int n_cmp = 0, n_fail = 0;

  region_mmu dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_wen(mem_wen), .mem_mode(mem_mode),
    .mem_addr(mem_addr), .mem_dat_i(mem_dat_i), .mem_dat_o(mem_dat_o), .mem_ready_o(mem_ready_o),
    .mem_fault_o(mem_fault_o), .fault_cause_o(fault_cause_o), .bus_req(bus_req), .bus_wen(bus_wen),
    .bus_mode(bus_mode), .bus_num(bus_num), .bus_addr(bus_addr), .bus_dat_o(bus_dat_o),
    .bus_dat_i(bus_dat_i), .bus_ready(bus_ready)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected decode result straight from the access rules: 0 ok, 1 badmode, 2 misalign, 3 unmapped, 4 wprot
  function automatic int ref_cause(input logic wen, input logic [2:0] mode, input logic [31:0] addr);
    int marks[4] = '{0, 8, 12, 10};
    bit wok[4] = '{0, 1, 1, 1};
    int bytes;
    if (mode inside {3'd3, 3'd6, 3'd7}) return 1;
    bytes = 1 << mode[1:0];
    if (addr % bytes != 0) return 2;
    for (int i = 0; i < 4; i++)
      if (int'(addr[31:28]) == marks[i]) return (wen && !wok[i]) ? 4 : 0;
    return 3;
  endfunction

  task automatic test_reset;
    tick;
    tick;
    n_cmp++;
    if ({mem_ready_o, mem_fault_o, fault_cause_o, bus_req} !== '0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b, want 0", {mem_ready_o, mem_fault_o, fault_cause_o, bus_req});
    end
    n_cmp++;
    if ({bus_wen, bus_mode, bus_num, bus_addr, bus_dat_o, mem_dat_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h, want 0", {bus_wen, bus_mode, bus_num, bus_addr, bus_dat_o, mem_dat_o});
    end
    rst_n = 1'b1;
    tick;
  endtask

  // dly: bus_ready asserted dly cycles after bus_req rises; negative means never
  task automatic run_access(input string nm, input logic wen, input logic [2:0] mode,
                            input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd, input int dly);
    int dec, ok_w, exp_c, exp_rdy, exp_flt, exp_req, ready_w, fault_w, req_n;
    bit moved;
    dec = ref_cause(wen, mode, addr);
    ok_w = (dly >= 0 && dly < 255) ? dly + 2 : -1;
    exp_c = dec != 0 ? dec : (ok_w < 0 ? 5 : 0);
    exp_rdy = exp_c == 0 ? ok_w : -1;
    exp_flt = dec != 0 ? 1 : (ok_w < 0 ? 256 : -1);
    exp_req = dec != 0 ? 0 : (ok_w < 0 ? 255 : dly + 1);
    ready_w = -1;
    fault_w = -1;
    req_n = 0;
    moved = 0;
    mem_req = 1'b1;
    mem_wen = wen;
    mem_mode = mode;
    mem_addr = addr;
    mem_dat_i = wd;
    tick;
    mem_req = 1'b0;
    for (int w = 1; w < 300; w++) begin
      if (mem_ready_o) begin ready_w = w; break; end
      if (mem_fault_o) begin fault_w = w; break; end
      if (bus_req) begin
        req_n++;
        if ({bus_num, bus_addr} !== addr || bus_wen !== wen || bus_mode !== mode || (wen && bus_dat_o !== wd))
          moved = 1;
      end
      mem_addr = $urandom;
      mem_wen = 1'($urandom);
      mem_mode = 3'($urandom);
      mem_dat_i = $urandom;
      bus_ready = (w == dly + 1);
      bus_dat_i = rd;
      tick;
    end
    bus_ready = 1'b0;
    n_cmp++;
    if (int'(fault_cause_o) !== exp_c) begin
      n_fail++;
      $display("FAIL %s cause: got %0d, want %0d", nm, fault_cause_o, exp_c);
    end
    n_cmp++;
    if (ready_w !== exp_rdy || fault_w !== exp_flt) begin
      n_fail++;
      $display("FAIL %s pulse_cycle: got ready@%0d fault@%0d, want ready@%0d fault@%0d", nm, ready_w, fault_w, exp_rdy, exp_flt);
    end
    n_cmp++;
    if (req_n !== exp_req || moved) begin
      n_fail++;
      $display("FAIL %s bus_req: got %0d cycles (fields_moved=%0d), want %0d cycles stable", nm, req_n, moved, exp_req);
    end
    if (exp_c == 0 && !wen) begin
      n_cmp++;
      if (mem_dat_o !== rd) begin
        n_fail++;
        $display("FAIL %s rdata: got %h, want %h", nm, mem_dat_o, rd);
      end
    end
    tick;
    n_cmp++;
    if (mem_ready_o || mem_fault_o) begin
      n_fail++;
      $display("FAIL %s pulse_width: got ready=%b fault=%b, want 0 0", nm, mem_ready_o, mem_fault_o);
    end
  endtask

  task automatic test_directed;
    run_access("lw_dmem", 1'b0, 3'b010, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 2);
    run_access("sw_imem", 1'b1, 3'b010, 32'h0000_0100, 32'h1111_2222, 32'h0, 0);
    run_access("lh_misalign", 1'b0, 3'b001, 32'hA000_0061, 32'h0, 32'h0, 0);
    run_access("lw_unmapped", 1'b0, 3'b010, 32'h1000_0000, 32'h0, 32'h0, 0);
    run_access("badmode_prio", 1'b0, 3'b111, 32'h8000_0001, 32'h0, 32'h0, 0);
    run_access("sw_fb", 1'b1, 3'b010, 32'hC000_0008, 32'hCAFE_F00D, 32'h5555_AAAA, 0);
    run_access("lhu_dev", 1'b0, 3'b101, 32'hA000_0102, 32'h0, 32'h0000_BEEF, 5);
  endtask

  task automatic test_timeout;
    run_access("timeout", 1'b0, 3'b010, 32'hA000_0000, 32'h0, 32'h0, -1);
    run_access("ready_at_limit", 1'b0, 3'b010, 32'hA000_0004, 32'h0, 32'h0BAD_F00D, 254);
    run_access("ready_last_ok", 1'b0, 3'b010, 32'hA000_0008, 32'h0, 32'h1357_9BDF, 253);
  endtask

  task automatic test_random;
    logic [3:0] tops[6] = '{4'h0, 4'h8, 4'hc, 4'ha, 4'h1, 4'h5};
    logic [31:0] a;
    for (int i = 0; i < 40; i++) begin
      a = {tops[$urandom_range(0, 5)], 28'($urandom_range(0, 255))};
      run_access("random", 1'($urandom), 3'($urandom_range(0, 7)), a, $urandom, $urandom, $urandom_range(0, 4));
    end
  endtask

  task automatic test_reset_mid_bus;
    bit bad = 0;
    mem_req = 1'b1;
    mem_wen = 1'b0;
    mem_mode = 3'b010;
    mem_addr = 32'h8000_0020;
    tick;
    mem_req = 1'b0;
    tick;
    n_cmp++;
    if (bus_req !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_bus_pre: got bus_req=%b, want 1", bus_req);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_async_drop: got bus_req=%b, want 0", bus_req);
    end
    bus_ready = 1'b1;
    repeat (3) begin
      tick;
      if (mem_ready_o || mem_fault_o || bus_req) bad = 1;
    end
    rst_n = 1'b1;
    repeat (4) begin
      tick;
      if (mem_ready_o || mem_fault_o || bus_req) bad = 1;
    end
    bus_ready = 1'b0;
    n_cmp++;
    if (bad) begin
      n_fail++;
      $display("FAIL rst_no_response: got a response or bus_req around reset, want none");
    end
    run_access("lw_after_reset", 1'b0, 3'b010, 32'h8000_0040, 32'h0, 32'h2468_ACE0, 1);
  endtask

  task automatic test_back_to_back;
    int req_w[$], rdy_w[$];
    bit f_ok = 1;
    mem_req = 1'b1;
    mem_wen = 1'b1;
    mem_mode = 3'b000;
    mem_addr = 32'hC000_0004;
    mem_dat_i = 32'h0000_00AB;
    bus_ready = 1'b1;
    bus_dat_i = 32'h1234_56A5;
    for (int w = 1; w <= 8; w++) begin
      tick;
      if (bus_req) begin
        req_w.push_back(w);
        if (req_w.size() == 1) begin
          if (!(bus_num == 4'hc && bus_addr == 28'h4 && bus_wen && bus_mode == 3'b000 && bus_dat_o == 32'hAB)) f_ok = 0;
          mem_wen = 1'b0;
          mem_mode = 3'b100;
          mem_addr = 32'h8000_0003;
        end else begin
          if (!(bus_num == 4'h8 && bus_addr == 28'h3 && !bus_wen && bus_mode == 3'b100)) f_ok = 0;
          mem_req = 1'b0;
        end
      end
      if (mem_ready_o) rdy_w.push_back(w);
    end
    bus_ready = 1'b0;
    mem_req = 1'b0;
    n_cmp++;
    if (req_w.size() != 2 || req_w[0] != 1 || req_w[1] != 4) begin
      n_fail++;
      $display("FAIL b2b_req_cycles: got %p, want '{1, 4}", req_w);
    end
    n_cmp++;
    if (rdy_w.size() != 2 || rdy_w[0] != 2 || rdy_w[1] != 5) begin
      n_fail++;
      $display("FAIL b2b_ready_cycles: got %p, want '{2, 5}", rdy_w);
    end
    n_cmp++;
    if (!f_ok) begin
      n_fail++;
      $display("FAIL b2b_fields: got wrong bus fields on a transaction, want SB C0000004 then LBU 80000003");
    end
    n_cmp++;
    if (mem_dat_o !== 32'h1234_56A5) begin
      n_fail++;
      $display("FAIL b2b_rdata: got %h, want 123456a5", mem_dat_o);
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_timeout;
    test_reset_mid_bus;
    test_back_to_back;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end
endmodule
